// File: rtl/jump_ctrl.sv
// Jump controller: decodes branch/jump/call/return instructions, issues
// relative or absolute jump requests to the program counter, squashes the
// wrong-path instruction that follows a taken jump, and maintains a small
// return-address stack with sticky overflow/underflow flags.
module jump_ctrl #(
  parameter int D  = 12,
  parameter int SD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic [2:0]           op,
  input  logic [D-1:0]         offset,
  input  logic                 zero_flag,
  input  logic [D-1:0]         prog_ctr,
  output logic                 reljump_en,
  output logic                 absjump_en,
  output logic [D-1:0]         target,
  output logic                 flush,
  output logic [$clog2(SD):0]  depth,
  output logic                 stack_ovf,
  output logic                 stack_udf
);

  localparam int DW = $clog2(SD) + 1;
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;

  localparam logic [D-1:0]  PC_ONE    = D'(1);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
  localparam logic [DW-1:0] FULL      = DW'(SD);

  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_BRZ  = 3'b010;
  localparam logic [2:0] OP_JMP  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  state_t          state;
  logic [D-1:0]    stack [SD];

  logic            take_rel;
  logic            take_abs;
  logic            do_push;
  logic            do_pop;
  logic            set_ovf;
  logic            set_udf;
  logic [D-1:0]    tgt_nxt;
  logic [AW-1:0]   top_idx;
  logic [AW-1:0]   push_idx;

  // Top-of-stack sits one below the occupancy count; pushes go at the count.
  assign top_idx  = AW'(depth - DEPTH_ONE);
  assign push_idx = AW'(depth);

  // Decode the presented instruction; only RUN with a valid instruction acts.
  always_comb begin
    take_rel = 1'b0;
    take_abs = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    set_ovf  = 1'b0;
    set_udf  = 1'b0;
    tgt_nxt  = '0;
    if (state == RUN && instr_valid) begin
      case (op)
        OP_BR: begin
          // The PC increments by one on its own, so the jump amount is offset-1.
          take_rel = 1'b1;
          tgt_nxt  = offset - PC_ONE;
        end
        OP_BRZ: begin
          if (zero_flag) begin
            take_rel = 1'b1;
            tgt_nxt  = offset - PC_ONE;
          end
        end
        OP_JMP: begin
          take_abs = 1'b1;
          tgt_nxt  = offset;
        end
        OP_CALL: begin
          // A full stack still jumps; only the link address is lost.
          take_abs = 1'b1;
          tgt_nxt  = offset;
          if (depth == FULL) set_ovf = 1'b1;
          else               do_push = 1'b1;
        end
        OP_RET: begin
          // Returning from an empty stack is not taken at all.
          if (depth != '0) begin
            take_abs = 1'b1;
            tgt_nxt  = stack[top_idx];
            do_pop   = 1'b1;
          end else begin
            set_udf = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, registered jump outputs, occupancy and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      reljump_en <= 1'b0;
      absjump_en <= 1'b0;
      target     <= '0;
      flush      <= 1'b0;
      depth      <= '0;
      stack_ovf  <= 1'b0;
      stack_udf  <= 1'b0;
    end else begin
      reljump_en <= take_rel;
      absjump_en <= take_abs;
      target     <= tgt_nxt;
      flush      <= take_rel | take_abs;
      state      <= (take_rel | take_abs) ? SQUASH : RUN;
      if (do_push)     depth <= depth + DEPTH_ONE;
      else if (do_pop) depth <= depth - DEPTH_ONE;
      if (set_ovf) stack_ovf <= 1'b1;
      if (set_udf) stack_udf <= 1'b1;
    end
  end

  // Return-address storage; contents are don't-care while depth is zero.
  always_ff @(posedge clk) begin
    if (do_push) stack[push_idx] <= prog_ctr + PC_ONE;
  end

endmodule

// File: tb/tb_jump_ctrl.sv
// Testbench for jump_ctrl: directed instruction sequence, a queue-based
// reference model checked every cycle, and hand-computed literal checks.
module tb_jump_ctrl;

  localparam int D  = 12;
  localparam int SD = 4;
  localparam int M  = 1 << D;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         instr_valid = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [D-1:0] offset = '0;
  logic         zero_flag = 1'b0;
  logic [D-1:0] prog_ctr = '0;
  logic         reljump_en;
  logic         absjump_en;
  logic [D-1:0] target;
  logic         flush;
  logic [$clog2(SD):0] depth;
  logic         stack_ovf;
  logic         stack_udf;

  int n_tests = 0;
  int n_fail  = 0;

  jump_ctrl #(.D(D), .SD(SD)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .op(op),
    .offset(offset), .zero_flag(zero_flag), .prog_ctr(prog_ctr),
    .reljump_en(reljump_en), .absjump_en(absjump_en), .target(target),
    .flush(flush), .depth(depth), .stack_ovf(stack_ovf), .stack_udf(stack_udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a squash flag, a queue of link addresses, expected outputs.
  int m_q[$];
  bit m_squash, m_rel, m_abs, m_flush, m_ovf, m_udf;
  int m_tgt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_squash = 0; m_rel = 0; m_abs = 0; m_flush = 0; m_ovf = 0; m_udf = 0;
      m_tgt = 0;
    end else begin
      m_rel = 0; m_abs = 0; m_tgt = 0;
      if (m_squash) begin
        m_squash = 0;
      end else if (instr_valid) begin
        case (int'(op))
          1: begin m_rel = 1; m_tgt = (int'(offset) + M - 1) % M; end
          2: if (zero_flag) begin m_rel = 1; m_tgt = (int'(offset) + M - 1) % M; end
          3: begin m_abs = 1; m_tgt = int'(offset); end
          4: begin
            m_abs = 1; m_tgt = int'(offset);
            if (m_q.size() < SD) m_q.push_back((int'(prog_ctr) + 1) % M);
            else m_ovf = 1;
          end
          5: begin
            if (m_q.size() > 0) begin m_abs = 1; m_tgt = m_q.pop_back(); end
            else m_udf = 1;
          end
          default: ;
        endcase
        m_squash = m_rel | m_abs;
      end
      m_flush = m_squash;
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(posedge clk) begin
    #1;
    check("reljump_en", 32'(reljump_en), 32'(m_rel));
    check("absjump_en", 32'(absjump_en), 32'(m_abs));
    check("target",     32'(target),     32'(m_tgt));
    check("flush",      32'(flush),      32'(m_flush));
    check("depth",      32'(depth),      32'(m_q.size()));
    check("stack_ovf",  32'(stack_ovf),  32'(m_ovf));
    check("stack_udf",  32'(stack_udf),  32'(m_udf));
    check("excl_jump",  32'(reljump_en & absjump_en), 32'(0));
  end

  // Present one instruction for one cycle, then land 2 time units after the edge.
  task automatic issue(input logic v, input logic [2:0] o, input int off,
                       input logic z, input int pc);
    @(negedge clk);
    instr_valid = v; op = o; offset = D'(off); zero_flag = z; prog_ctr = D'(pc);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    issue(1'b0, 3'b000, 0, 1'b0, 0);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_depth", 32'(depth), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_target", 32'(target), 0);
    check("rst_flags", 32'({stack_ovf, stack_udf}), 0);
    @(negedge clk) reset = 1'b0;

    // BR at 0x010 by +5, accepted in first cycle after reset.
    issue(1, 3'b001, 'h005, 0, 'h010);
    check("br_rel", 32'(reljump_en), 1);
    check("br_target", 32'(target), 'h004);
    check("br_flush", 32'(flush), 1);
    check("br_land", 32'((32'h010 + 32'(target) + 1) % M), 'h015);
    idle();
    check("br_clear", 32'({reljump_en, flush}), 0);

    // BRZ untaken, then taken with wrap.
    issue(1, 3'b010, 'h123, 0, 'h002);
    check("brz0_flush", 32'(flush), 0);
    check("brz0_rel", 32'(reljump_en), 0);
    issue(1, 3'b010, 'hFFE, 1, 'h001);
    check("brz1_target", 32'(target), 'hFFD);
    check("brz1_land", 32'((32'h001 + 32'(target) + 1) % M), 'hFFF);
    idle();

    // CALL / RET pair.
    issue(1, 3'b100, 'h100, 0, 'h020);
    check("call_abs", 32'(absjump_en), 1);
    check("call_target", 32'(target), 'h100);
    check("call_depth", 32'(depth), 1);
    idle();
    issue(1, 3'b101, 0, 0, 'h105);
    check("ret_target", 32'(target), 'h021);
    check("ret_depth", 32'(depth), 0);
    idle();

    // Five nested CALLs into a four-deep stack.
    for (int i = 0; i < 5; i++) begin
      issue(1, 3'b100, 'h300 + i, 0, 'h200 + i * 'h10);
      check("ncall_abs", 32'(absjump_en), 1);
      idle();
    end
    check("ovf_depth", 32'(depth), 4);
    check("ovf_flag", 32'(stack_ovf), 1);
    for (int i = 3; i >= 0; i--) begin
      issue(1, 3'b101, 0, 0, 'h400);
      check("lifo_target", 32'(target), 'h201 + i * 'h10);
      idle();
    end
    check("lifo_depth", 32'(depth), 0);

    // RET on empty stack, then a JMP accepted immediately.
    issue(1, 3'b101, 0, 0, 'h050);
    check("udf_flush", 32'(flush), 0);
    check("udf_abs", 32'(absjump_en), 0);
    check("udf_flag", 32'(stack_udf), 1);
    issue(1, 3'b011, 'h0AB, 0, 'h051);
    check("jmp_target", 32'(target), 'h0AB);
    check("udf_held", 32'(stack_udf), 1);
    // CALL presented during SQUASH is ignored.
    issue(1, 3'b100, 'h555, 0, 'h052);
    check("sq_depth", 32'(depth), 0);
    check("sq_flush", 32'(flush), 0);

    // Unused opcodes and NOP.
    issue(1, 3'b110, 'h777, 1, 'h060);
    issue(1, 3'b111, 'h777, 1, 'h061);
    issue(1, 3'b000, 'h777, 1, 'h062);
    check("nop_flush", 32'(flush), 0);

    // Reset mid-SQUASH.
    issue(1, 3'b100, 'h070, 0, 'h060);
    check("pre_rst_depth", 32'(depth), 1);
    instr_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("mid_rst_flush", 32'(flush), 0);
    check("mid_rst_depth", 32'(depth), 0);
    check("mid_rst_abs", 32'(absjump_en), 0);
    check("mid_rst_flags", 32'({stack_ovf, stack_udf}), 0);
    @(negedge clk) reset = 1'b0;
    issue(1, 3'b001, 'h010, 0, 'h000);
    check("post_rst_br", 32'({reljump_en, flush}), 3);
    check("post_rst_target", 32'(target), 'h00F);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jump_ctrl.md
JUMP_CTRL -- requirements
Module: jump_ctrl

Interface
REQ-001 The module SHALL have parameter D, default 12, the program-counter width in bits.
REQ-002 The module SHALL have parameter SD, default 4, the return-stack depth in entries.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port instr_valid, input, 1 bit: an instruction is presented this cycle.
REQ-006 The module SHALL have port op, input, 3 bits: 000 NOP, 001 BR, 010 BRZ, 011 JMP, 100 CALL, 101 RET, 110/111 treated as NOP.
REQ-007 The module SHALL have port offset, input, D bits: the relative displacement for BR/BRZ, or the absolute address for JMP/CALL.
REQ-008 The module SHALL have port zero_flag, input, 1 bit: the BRZ condition.
REQ-009 The module SHALL have port prog_ctr, input, D bits: the address of the presented instruction.
REQ-010 The module SHALL have port reljump_en, output, 1 bit: relative-jump request to the program counter.
REQ-011 The module SHALL have port absjump_en, output, 1 bit: absolute-jump request to the program counter.
REQ-012 The module SHALL have port target, output, D bits: the jump amount or address.
REQ-013 The module SHALL have port flush, output, 1 bit: the presented instruction is wrong-path and is squashed.
REQ-014 The module SHALL have port depth, output, clog2(SD)+1 bits: current return-stack occupancy.
REQ-015 The module SHALL have port stack_ovf, output, 1 bit: sticky overflow flag.
REQ-016 The module SHALL have port stack_udf, output, 1 bit: sticky underflow flag.

Function
REQ-017 The module SHALL contain a two-state FSM, RUN and SQUASH.
REQ-018 In RUN, an instruction SHALL be accepted when instr_valid=1.
REQ-019 In SQUASH, instr_valid SHALL be ignored and flush=1.
REQ-020 An accepted instruction is "taken" for BR, JMP, CALL, RET with depth>0, and BRZ with zero_flag=1; a taken instruction SHALL move the FSM RUN->SQUASH at the next edge.
REQ-021 SQUASH SHALL always return to RUN after exactly one cycle.
REQ-022 reljump_en, absjump_en and target SHALL be registered outputs, valid in the cycle after acceptance (the SQUASH cycle), and 0 in all other cycles.
REQ-023 For taken BR/BRZ: reljump_en=1 and target=offset-1 mod 2^D, so that the program counter lands at issue address + offset (mod 2^D).
REQ-024 For JMP: absjump_en=1 and target=offset.
REQ-025 For CALL: absjump_en=1 and target=offset, and prog_ctr+1 (mod 2^D) SHALL be pushed onto the return stack.
REQ-026 For RET with depth>0: absjump_en=1, target=top of stack, and the stack SHALL be popped.
REQ-027 For CALL with depth=SD: the jump SHALL still be taken, the push SHALL be dropped, the stack SHALL be left unchanged, and stack_ovf SHALL be set.
REQ-028 For RET with depth=0: the instruction SHALL not be taken, there SHALL be no jump and no SQUASH, and stack_udf SHALL be set.
REQ-029 Untaken BRZ, NOP and codes 110/111 SHALL produce no outputs and no state change.
REQ-030 reljump_en and absjump_en SHALL never both be 1.
REQ-031 stack_ovf and stack_udf SHALL stay at 1 until reset.

Reset
REQ-032 Asserting reset SHALL asynchronously force, at any time including mid-SQUASH: FSM=RUN, depth=0, all outputs=0 (target=0, flush=0, stack_ovf=0, stack_udf=0).
REQ-033 Return-stack contents need not be cleared by reset.
REQ-034 The first instruction SHALL be accepted in the first cycle after reset deasserts.

Verification
REQ-035 BR: prog_ctr=0x010, offset=0x005 -> next cycle reljump_en=1, target=0x004, flush=1; the program counter lands at 0x015.
REQ-036 BRZ with zero_flag=0 -> no jump, flush stays 0; then BRZ with zero_flag=1, offset=0xFFE at prog_ctr=0x001 -> target=0xFFD, and the program counter lands at 0xFFF (wrap).
REQ-037 CALL at 0x020 to 0x100, then RET at 0x105 -> absjump_en=1, target=0x100, then target=0x021; depth goes 0->1->0.
REQ-038 5 nested CALLs (SD=4) -> depth saturates at 4, stack_ovf=1; the 5th jump is still taken; 4 RETs return the first 4 link addresses in LIFO order.
REQ-039 RET at depth 0 -> no jump, flush=0, stack_udf=1 and held.
REQ-040 Instruction presented during SQUASH is ignored (a CALL pushes nothing); reset asserted mid-SQUASH -> flush=0 and depth=0 immediately.
